food_placer: RTL
================

FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 10, meaning cells per grid row.
REQ-002 SHALL have parameter CELL_MIN, default 12, meaning lowest legal cell index.
REQ-003 SHALL have parameter CELL_MAX, default 89, meaning highest legal cell index.
REQ-004 SHALL have parameter MAX_TRIES, default 8, meaning random candidate pairs tried before fallback.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port cand_a, input, 8, meaning first candidate cell from the random source.
REQ-008 SHALL have port cand_b, input, 8, meaning second candidate cell from the random source.
REQ-009 SHALL have port eaten, input, 1, meaning a one-cycle pulse when the snake head reaches the food.
REQ-010 SHALL have port occ_req, output, 1, meaning an occupancy lookup request.
REQ-011 SHALL have port occ_addr, output, 8, meaning the cell being looked up.
REQ-012 SHALL have port occ_hit, input, 1, meaning the cell is occupied by the snake, valid the cycle after occ_req.
REQ-013 SHALL have port food_pos, output, 8, meaning the current food cell.
REQ-014 SHALL have port food_valid, output, 1, meaning food_pos is placed and stable.
REQ-015 SHALL have port place_fail, output, 1, meaning no free cell was found.

Function
REQ-016 SHALL implement FSM states SAMPLE, QRY_A, CHK_A, QRY_B, CHK_B, PLACED, plus SCAN_Q, SCAN_C and FULL when FOOD_SCAN_EN is defined.
REQ-017 SHALL register cand_a and cand_b on the edge leaving SAMPLE; later changes on the inputs are ignored until the next SAMPLE.
REQ-018 SHALL treat a candidate as legal only if it lies in CELL_MIN..CELL_MAX and (cand mod GRID_W) is not 0 or 1.
REQ-019 SHALL skip an illegal candidate as occupied, issuing no lookup, with the next state taken as if occ_hit=1.
REQ-020 SHALL assert occ_req=1 with occ_addr set to the candidate only in query states; otherwise occ_req=0 and occ_addr=0.
REQ-021 SHALL go from CHK_A to PLACED with food_pos=cand_a if occ_hit=0, and otherwise to QRY_B.
REQ-022 SHALL go from CHK_B to PLACED with food_pos=cand_b if occ_hit=0, and otherwise increment the 4-bit try counter and return to SAMPLE.
REQ-023 SHALL place food from a free cand_a so that food_valid rises on the third edge after the edge that samples eaten.
REQ-024 SHALL hold food_valid=1 and food_pos constant in PLACED; eaten in PLACED drops food_valid on the next edge, clears the try counter and enters SAMPLE.
REQ-025 SHALL ignore eaten in every state other than PLACED.
REQ-026 SHALL, when the try counter reaches MAX_TRIES, follow the Configuration rules below.
REQ-027 SHALL place food only after occ_hit=0 for that exact cell, and clear place_fail on the edge that sets food_valid.

Reset
REQ-028 SHALL on rst (including mid-search) force state=SAMPLE, food_valid=0, food_pos=0, occ_req=0, occ_addr=0, place_fail=0, try counter=0 and scan index=0.
REQ-029 SHALL begin placing the first food on the first edge after rst deasserts, with no eaten required.

Configuration
REQ-030 SHALL, with macro FOOD_SCAN_EN defined, enter SCAN_Q/SCAN_C at MAX_TRIES and scan cells CELL_MIN upward.
REQ-031 SHALL in scan skip illegal cells with no lookup and place food at the first cell with occ_hit=0.
REQ-032 SHALL in scan, if it passes CELL_MAX with no free cell, enter FULL with place_fail=1 and food_valid=0, held until rst.
REQ-033 SHALL, without FOOD_SCAN_EN, set place_fail=1 at MAX_TRIES, clear the try counter and continue random retries indefinitely.

Structure
REQ-034 SHALL define the FSM state enum and the default constants (GRID_W, CELL_MIN, CELL_MAX) in shared package snake_pkg.
REQ-035 SHALL use one sub-module, cell_legal, a combinational legality check shared by the candidate and scan paths.

Verification
REQ-036 SHALL test: rst released with cand_a=23 and occ_hit=0 -> food_pos=23 and food_valid=1 on the third edge.
REQ-037 SHALL test: cand_a=23 occupied and cand_b=45 free -> food_pos=45 and exactly two occ_req pulses seen.
REQ-038 SHALL test: cand_a=30 and cand_b=91 -> no lookup for either, SAMPLE re-entered and try counter=1.
REQ-039 SHALL test: all lookups hit with FOOD_SCAN_EN and only cell 88 free -> after 8 tries food_pos=88.
REQ-040 SHALL test: all lookups hit -> with FOOD_SCAN_EN, FULL state and place_fail=1 held; without it, place_fail=1 and retries continue.
REQ-041 SHALL test: rst pulsed during CHK_B and eaten pulsed during QRY_A -> clean restart from SAMPLE, and eaten ignored.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : snake_pkg                                                  |
// | Description : Shared types and default grid constants for the snake      |
// |               game blocks: food-placer FSM state encoding and the        |
// |               default playfield geometry.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package snake_pkg;

    localparam int c_GRID_W   = 10;   // cells per grid row
    localparam int c_CELL_MIN = 12;   // lowest legal cell index
    localparam int c_CELL_MAX = 89;   // highest legal cell index

    // Food placer states. SCAN_Q, SCAN_C and FULL are reachable only when
    // the linear-scan fallback is built in.
    typedef enum logic [3:0] {
        SAMPLE = 4'd0,
        QRY_A  = 4'd1,
        CHK_A  = 4'd2,
        QRY_B  = 4'd3,
        CHK_B  = 4'd4,
        PLACED = 4'd5,
        SCAN_Q = 4'd6,
        SCAN_C = 4'd7,
        FULL   = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cell_legal.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cell_legal                                                 |
// | Description : Combinational legality check for a grid cell. A cell is    |
// |               legal when it lies in CELL_MIN..CELL_MAX and its column    |
// |               (cell mod GRID_W) is neither 0 nor 1 (the wall columns).   |
// | Ports       : i_cell  [7:0] cell index under test                        |
// |               o_legal       1 when the cell may hold food                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cell_legal
    import snake_pkg::*;
#(
    parameter int GRID_W   = c_GRID_W,
    parameter int CELL_MIN = c_CELL_MIN,
    parameter int CELL_MAX = c_CELL_MAX
) (
    input  logic [7:0] i_cell,
    output logic       o_legal
);

    localparam logic [7:0] c_GRID = 8'(GRID_W);
    localparam logic [7:0] c_MIN  = 8'(CELL_MIN);
    localparam logic [7:0] c_MAX  = 8'(CELL_MAX);

    logic [7:0] w_col;

    assign w_col   = i_cell % c_GRID;
    assign o_legal = (i_cell >= c_MIN) && (i_cell <= c_MAX) &&
                     (w_col != 8'd0) && (w_col != 8'd1);

endmodule
`default_nettype wire

// File: rtl/food_placer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : food_placer                                                |
// | Description : Places snake food on a free, legal grid cell. Each round   |
// |               samples two random candidates, looks each up in the snake  |
// |               occupancy store and places food on the first free one.     |
// |               After MAX_TRIES failed rounds the fallback depends on the  |
// |               build macro FOOD_SCAN_EN:                                  |
// |                 defined   - linear scan from CELL_MIN; FULL if none free |
// |                 undefined - flag place_fail and keep retrying randomly   |
// | Ports       : clk, rst         clock, synchronous active-high reset      |
// |               cand_a, cand_b   random candidate cells                    |
// |               eaten            head reached food (acted on in PLACED)    |
// |               occ_req/occ_addr occupancy lookup request and cell         |
// |               occ_hit          lookup result, valid cycle after occ_req  |
// |               food_pos/valid   placed food cell and its qualifier        |
// |               place_fail       no free cell found                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module food_placer
    import snake_pkg::*;
#(
    parameter int GRID_W    = c_GRID_W,
    parameter int CELL_MIN  = c_CELL_MIN,
    parameter int CELL_MAX  = c_CELL_MAX,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cand_a,
    input  logic [7:0] cand_b,
    input  logic       eaten,
    output logic       occ_req,
    output logic [7:0] occ_addr,
    input  logic       occ_hit,
    output logic [7:0] food_pos,
    output logic       food_valid,
    output logic       place_fail
);

    localparam logic [3:0] c_MAX_TRIES = 4'(MAX_TRIES);

    state_t     r_state;
    logic [7:0] r_cand_a;
    logic [7:0] r_cand_b;
    logic [3:0] r_try;
    logic       r_cur_legal;   // legality of the cell whose lookup is in flight
    logic       r_occ_req;
    logic [7:0] r_occ_addr;
    logic [7:0] r_food_pos;
    logic       r_food_valid;
    logic       r_place_fail;

    logic [7:0] w_chk_cell;    // cell about to be queried on the next edge
    logic       w_legal;
    logic       w_free;
    logic [3:0] w_try_nxt;

`ifdef FOOD_SCAN_EN
    localparam logic [7:0] c_CELL_MIN = 8'(CELL_MIN);
    localparam logic [7:0] c_CELL_MAX = 8'(CELL_MAX);

    logic [7:0] r_scan_idx;
    logic [7:0] w_scan_nxt;

    assign w_scan_nxt = r_scan_idx + 8'd1;
`endif

    // An illegal cell is never looked up and counts as occupied.
    assign w_free    = r_cur_legal && !occ_hit;
    assign w_try_nxt = r_try + 4'd1;

    // One legality checker serves every path: it always looks at the cell
    // the FSM would query next from its current state.
    always_comb begin
        w_chk_cell = 8'd0;
        case (r_state)
            SAMPLE: w_chk_cell = cand_a;
            CHK_A:  w_chk_cell = r_cand_b;
`ifdef FOOD_SCAN_EN
            CHK_B:  w_chk_cell = c_CELL_MIN;
            SCAN_C: w_chk_cell = w_scan_nxt;
`endif
            default: w_chk_cell = 8'd0;
        endcase
    end

    cell_legal #(
        .GRID_W   (GRID_W),
        .CELL_MIN (CELL_MIN),
        .CELL_MAX (CELL_MAX)
    ) u_cell_legal (
        .i_cell  (w_chk_cell),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SAMPLE;
            r_cand_a     <= 8'd0;
            r_cand_b     <= 8'd0;
            r_try        <= 4'd0;
            r_cur_legal  <= 1'b0;
            r_occ_req    <= 1'b0;
            r_occ_addr   <= 8'd0;
            r_food_pos   <= 8'd0;
            r_food_valid <= 1'b0;
            r_place_fail <= 1'b0;
`ifdef FOOD_SCAN_EN
            r_scan_idx   <= 8'd0;
`endif
        end else begin
            // Lookup outputs are high only for the single query-state cycle.
            r_occ_req  <= 1'b0;
            r_occ_addr <= 8'd0;
            case (r_state)
                SAMPLE: begin
                    r_cand_a    <= cand_a;
                    r_cand_b    <= cand_b;
                    r_cur_legal <= w_legal;
                    r_occ_req   <= w_legal;
                    r_occ_addr  <= w_legal ? cand_a : 8'd0;
                    r_state     <= QRY_A;
                end
                QRY_A: r_state <= CHK_A;
                CHK_A: begin
                    if (w_free) begin
                        r_food_pos   <= r_cand_a;
                        r_food_valid <= 1'b1;
                        r_place_fail <= 1'b0;
                        r_state      <= PLACED;
                    end else begin
                        r_cur_legal <= w_legal;
                        r_occ_req   <= w_legal;
                        r_occ_addr  <= w_legal ? r_cand_b : 8'd0;
                        r_state     <= QRY_B;
                    end
                end
                QRY_B: r_state <= CHK_B;
                CHK_B: begin
                    if (w_free) begin
                        r_food_pos   <= r_cand_b;
                        r_food_valid <= 1'b1;
                        r_place_fail <= 1'b0;
                        r_state      <= PLACED;
                    end else if (w_try_nxt == c_MAX_TRIES) begin
`ifdef FOOD_SCAN_EN
                        r_try       <= w_try_nxt;
                        r_scan_idx  <= c_CELL_MIN;
                        r_cur_legal <= w_legal;
                        r_occ_req   <= w_legal;
                        r_occ_addr  <= w_legal ? c_CELL_MIN : 8'd0;
                        r_state     <= SCAN_Q;
`else
                        r_place_fail <= 1'b1;
                        r_try        <= 4'd0;
                        r_state      <= SAMPLE;
`endif
                    end else begin
                        r_try   <= w_try_nxt;
                        r_state <= SAMPLE;
                    end
                end
                PLACED: begin
                    if (eaten) begin
                        r_food_valid <= 1'b0;
                        r_try        <= 4'd0;
                        r_state      <= SAMPLE;
                    end
                end
`ifdef FOOD_SCAN_EN
                SCAN_Q: r_state <= SCAN_C;
                SCAN_C: begin
                    if (w_free) begin
                        r_food_pos   <= r_scan_idx;
                        r_food_valid <= 1'b1;
                        r_place_fail <= 1'b0;
                        r_state      <= PLACED;
                    end else if (r_scan_idx == c_CELL_MAX) begin
                        r_place_fail <= 1'b1;
                        r_state      <= FULL;
                    end else begin
                        r_scan_idx  <= w_scan_nxt;
                        r_cur_legal <= w_legal;
                        r_occ_req   <= w_legal;
                        r_occ_addr  <= w_legal ? w_scan_nxt : 8'd0;
                        r_state     <= SCAN_Q;
                    end
                end
                // Grid exhausted: hold until reset.
                FULL: r_state <= FULL;
`endif
                default: r_state <= SAMPLE;
            endcase
        end
    end

    assign occ_req    = r_occ_req;
    assign occ_addr   = r_occ_addr;
    assign food_pos   = r_food_pos;
    assign food_valid = r_food_valid;
    assign place_fail = r_place_fail;

endmodule
`default_nettype wire
